jtopl_pg_mslot: RTL
===================

Name: jtopl_pg_mslot

Overview:
- Time-multiplexed, pipelined phase generator for all operator slots of an OPL-family core.
- Slot parameters are presented serially, one slot per enabled cycle.
- Computes vibrato-adjusted phase increment, applies the multiplier, accumulates into per-slot phase storage, and emits the operator phase two enabled cycles later.
- Replaces per-slot combinational phase logic plus external phase shift registers; slot count and widths are parametrised for OPL/OPL2/OPLL/OPL3-style cores.

Parameters:
- SLOTS, 18, number of operator slots in the multiplex cycle (2..64).
- FNUM_W, 10, F-number width (>=4).
- PHASE_W, 19, phase accumulator width (>= FNUM_W+8).
- OUT_W, 10, operator phase output width (<= PHASE_W).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- cen  in  1  clock enable; all state advances only when cen=1.
- block  in  3  octave for the current slot.
- fnum  in  FNUM_W  F-number for the current slot.
- mul  in  4  multiplier code.
- vib_cnt  in  3  global vibrato phase.
- vib_dep  in  1  1 = deep vibrato, 0 = shallow.
- viben  in  1  vibrato enable for the slot.
- pg_rst  in  1  clear this slot's phase (key-on).
- zero  out  1  high while the input slot counter is 0 (input side).
- keycode  out  4  {block, fnum[FNUM_W-1]}; combinational from the inputs.
- slot_out  out  6  slot index of phase_op.
- phase_op  out  OUT_W  operator phase for slot_out.

Behaviour:
- Slot counter
  - Reset value 0.
  - On cen, increments; wraps from SLOTS-1 to 0.
  - zero = (counter==0).
- Stage 1 (registered on cen)
  - Vibrato offset: b = fnum[FNUM_W-1 -: 3], unsigned.
  - Magnitude by vib_cnt: 0→0, 1→b>>1, 2→b, 3→b>>1, 4→0, 5→b>>1, 6→b, 7→b>>1.
  - vib_cnt 5..7 negate the magnitude.
  - vib_dep=0 arithmetically shifts the offset right by 1.
  - viben=0 forces the offset to 0.
  - Offset is 4-bit signed.
  - fm = fnum + sign-extended offset, computed in FNUM_W+1 bits, two's-complement wrap.
  - phinc = (fm << block) >> 1, truncated to PHASE_W bits.
  - Registered with slot index, mul, pg_rst.
- Stage 2 (registered on cen)
  - mul factor (×2 scale), codes 0..15: 1,2,4,6,8,10,12,14,16,18,20,20,24,24,30,30.
  - inc = (phinc × factor) >> 1.
  - Read mem[slot]; next = pg_rst ? 0 : mem[slot] + inc, mod 2^PHASE_W.
  - Write next back to mem[slot].
  - phase_op = next[PHASE_W-1 -: OUT_W].
  - slot_out = slot.
- Latency: inputs for slot s seen at enabled cycle n → phase_op/slot_out for s valid after enabled cycle n+2.
- Memory access: read and write of the same slot never coincide within one stage.
  - A slot is revisited only after SLOTS enabled cycles.
  - SLOTS >= 2 guarantees no hazard.
  - No bypass logic is required.
- cen=0: counter, pipeline, memory and outputs hold.
- Reset: asserting rst_n low at any time, including mid-frame, gives:
  - counter = 0, every mem entry = 0, pipeline registers = 0;
  - phase_op = 0, slot_out = 0.
  - After release, slot 0 is first again.
- pg_rst with mul=0 or fnum=0 still clears to 0.
- inc=0 holds the phase.
- Overflow wraps silently.

Test Plan:
- Reset: hold rst_n=0 with random inputs and cen=1 → phase_op=0, slot_out=0, zero=1. Release → zero pulses every SLOTS (18) enabled cycles.
- Basic increment (FNUM_W=10, PHASE_W=19, OUT_W=10), slot 0 only, others fnum=0:
  - Stimulus: fnum=0x200, block=4, mul=1, viben=0.
  - Per-visit inc = 0x1000.
  - After 8th visit: phase_op=0x040.
  - After 128th visit: wraps to 0x000.
- Multiplier: same fnum/block with mul=0 → inc 0x0800. mul=15 → inc 0xF000. mul=11 and 10 → identical results.
- Vibrato: fnum=0x380 (b=7), block=1, viben=1, vib_dep=1.
  - vib_cnt=2 → phinc 0x387.
  - vib_cnt=6 → phinc 0x379.
  - vib_dep=0, vib_cnt=2 → phinc 0x383.
  - viben=0 → 0x380.
- Key-on: accumulate slot 5 to non-zero, then assert pg_rst on one visit → that visit outputs 0; other slots are unaffected.
- cen gating and mid-frame reset: toggle cen randomly → results match a cen=1 reference model. Pulse rst_n low mid-frame → all phases restart from 0 and the slot counter restarts at 0.

Source files
------------

// File: rtl/jtopl_pg_mslot.sv
// Time-multiplexed phase generator for all operator slots of an OPL-family core.
// Slot parameters arrive serially, one slot per enabled cycle. Stage 1 forms the
// vibrato-adjusted, block-shifted phase increment. Stage 2 applies the multiplier,
// accumulates into per-slot phase storage and registers the operator phase.
// The phase for the slot presented at enabled cycle n is valid after cycle n+2.
module jtopl_pg_mslot #(
    parameter int SLOTS   = 18,
    parameter int FNUM_W  = 10,
    parameter int PHASE_W = 19,
    parameter int OUT_W   = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cen,
    input  logic [2:0]        block,
    input  logic [FNUM_W-1:0] fnum,
    input  logic [3:0]        mul,
    input  logic [2:0]        vib_cnt,
    input  logic              vib_dep,
    input  logic              viben,
    input  logic              pg_rst,
    output logic              zero,
    output logic [3:0]        keycode,
    output logic [5:0]        slot_out,
    output logic [OUT_W-1:0]  phase_op
);

    localparam int IDX_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam int FM_W  = FNUM_W + 1;

    // Multiplier factor at twice its real value so that code 0 (x0.5) stays integral.
    function automatic logic [4:0] mul_factor(input logic [3:0] code);
        logic [4:0] f;
        case (code)
            4'd0:    f = 5'd1;
            4'd1:    f = 5'd2;
            4'd2:    f = 5'd4;
            4'd3:    f = 5'd6;
            4'd4:    f = 5'd8;
            4'd5:    f = 5'd10;
            4'd6:    f = 5'd12;
            4'd7:    f = 5'd14;
            4'd8:    f = 5'd16;
            4'd9:    f = 5'd18;
            4'd10:   f = 5'd20;
            4'd11:   f = 5'd20;
            4'd12:   f = 5'd24;
            4'd13:   f = 5'd24;
            4'd14:   f = 5'd30;
            4'd15:   f = 5'd30;
            default: f = 5'd1;
        endcase
        return f;
    endfunction

    // Slot counter and its wrap
    logic [5:0] cnt_q;
    logic [5:0] cnt_d;

    // Stage 1 registers
    logic [5:0]         s1_slot_q;
    logic [3:0]         s1_mul_q;
    logic               s1_pgrst_q;
    logic [PHASE_W-1:0] s1_phinc_q;

    // Stage 1 combinational terms
    logic [2:0]         vib_b_s;
    logic [2:0]         vib_mag_s;
    logic [3:0]         vib_raw_s;
    logic [3:0]         vib_off_s;
    logic [FM_W-1:0]    fm_s;
    logic [PHASE_W:0]   fm_sh_s;
    logic [PHASE_W-1:0] phinc_d;

    // Stage 2 terms and storage
    logic [4:0]           fac_s;
    logic [PHASE_W+4:0]   prod_s;
    logic [PHASE_W-1:0]   inc_s;
    logic [PHASE_W-1:0]   rd_s;
    logic [PHASE_W-1:0]   next_d;
    logic [PHASE_W-1:0]   mem_q [SLOTS];
    logic [5:0]           slot_out_q;
    logic [OUT_W-1:0]     phase_op_q;

    assign zero     = (cnt_q == 6'd0);
    assign keycode  = {block, fnum[FNUM_W-1]};
    assign slot_out = slot_out_q;
    assign phase_op = phase_op_q;

    // Next slot index, wrapping after the last slot of the frame
    always_comb begin
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'(SLOTS - 1)) begin
            cnt_d = 6'd0;
        end else begin
            cnt_d = cnt_q + 6'd1;
        end
    end

    // Slot counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 6'd0;
        end else if (cen) begin
            cnt_q <= cnt_d;
        end
    end

    // Vibrato offset from the top F-number bits, then block-shifted increment
    always_comb begin
        vib_b_s = fnum[FNUM_W-1 -: 3];
        case (vib_cnt[1:0])
            2'd0:    vib_mag_s = 3'd0;
            2'd1:    vib_mag_s = {1'b0, vib_b_s[2:1]};
            2'd2:    vib_mag_s = vib_b_s;
            2'd3:    vib_mag_s = {1'b0, vib_b_s[2:1]};
            default: vib_mag_s = 3'd0;
        endcase
        // Second half of the vibrato cycle swings below the nominal pitch
        if (vib_cnt[2]) begin
            vib_raw_s = 4'd0 - {1'b0, vib_mag_s};
        end else begin
            vib_raw_s = {1'b0, vib_mag_s};
        end
        // Shallow vibrato halves the offset, keeping its sign
        if (!vib_dep) begin
            vib_off_s = {vib_raw_s[3], vib_raw_s[3:1]};
        end else begin
            vib_off_s = vib_raw_s;
        end
        if (!viben) begin
            vib_off_s = 4'd0;
        end else begin
            vib_off_s = vib_off_s;
        end
        fm_s    = {1'b0, fnum} + {{(FM_W-4){vib_off_s[3]}}, vib_off_s};
        fm_sh_s = {{(PHASE_W+1-FM_W){1'b0}}, fm_s} << block;
        phinc_d = fm_sh_s[PHASE_W:1];
    end

    // Stage 1 pipeline register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_slot_q  <= 6'd0;
            s1_mul_q   <= 4'd0;
            s1_pgrst_q <= 1'b0;
            s1_phinc_q <= '0;
        end else if (cen) begin
            s1_slot_q  <= cnt_q;
            s1_mul_q   <= mul;
            s1_pgrst_q <= pg_rst;
            s1_phinc_q <= phinc_d;
        end
    end

    // Multiplied increment and the slot's next accumulated phase
    always_comb begin
        fac_s  = mul_factor(s1_mul_q);
        prod_s = {{5{1'b0}}, s1_phinc_q} * {{PHASE_W{1'b0}}, fac_s};
        inc_s  = prod_s[PHASE_W:1];
        rd_s   = mem_q[s1_slot_q[IDX_W-1:0]];
        if (s1_pgrst_q) begin
            next_d = '0;
        end else begin
            next_d = rd_s + inc_s;
        end
    end

    // Per-slot phase storage; each slot is touched once per frame so no bypass is needed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SLOTS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (cen) begin
            mem_q[s1_slot_q[IDX_W-1:0]] <= next_d;
        end
    end

    // Registered operator phase and its slot tag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_out_q <= 6'd0;
            phase_op_q <= '0;
        end else if (cen) begin
            slot_out_q <= s1_slot_q;
            phase_op_q <= next_d[PHASE_W-1 -: OUT_W];
        end
    end

endmodule
